// File: rtl/mips150_lsu_pkg.sv
// Shared encodings for the MIPS150 load/store unit: access sizes, error codes,
// FSM states and the alignment check.
package mips150_lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            SZ_HALF:  return lo[0];
            SZ_WORD:  return |lo[1:0];
            SZ_DWORD: return |lo;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips150_lsu_lane.sv
// Combinational big-endian lane formatter: positions store data / byte enables
// and extracts plus sign/zero-extends load data.
module mips150_lsu_lane
    import mips150_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   st_size,
    input  logic [$clog2(DATA_W/8)-1:0]  st_offset,
    input  logic [DATA_W-1:0]            st_wdata,
    output logic [DATA_W/8-1:0]          st_be,
    output logic [DATA_W-1:0]            st_data,
    input  logic [1:0]                   ld_size,
    input  logic [$clog2(DATA_W/8)-1:0]  ld_offset,
    input  logic                         ld_unsigned,
    input  logic [DATA_W-1:0]            ld_rdata,
    output logic [DATA_W-1:0]            ld_data
);
    localparam int NB = DATA_W / 8;

    int          st_bytes, st_shift, ld_bytes, ld_shift;
    logic [DATA_W-1:0] ld_raw, ld_mask;
    logic              ld_sign;

    always_comb begin
        // Offset 0 is the most significant lane, so the access sits
        // (NB - offset - bytes) lanes above the LSB.
        st_bytes = 1 << st_size;
        if (st_bytes > NB) st_bytes = NB;
        st_shift = NB - int'(st_offset) - st_bytes;
        if (st_shift < 0) st_shift = 0;
        st_be   = NB'(((1 << st_bytes) - 1) << st_shift);
        st_data = (st_wdata & ({DATA_W{1'b1}} >> (DATA_W - 8 * st_bytes))) << (8 * st_shift);

        ld_bytes = 1 << ld_size;
        if (ld_bytes > NB) ld_bytes = NB;
        ld_shift = NB - int'(ld_offset) - ld_bytes;
        if (ld_shift < 0) ld_shift = 0;
        ld_raw  = ld_rdata >> (8 * ld_shift);
        ld_mask = {DATA_W{1'b1}} >> (DATA_W - 8 * ld_bytes);
        // The top bit of the mask selects the sign bit of the extracted value.
        ld_sign = ~ld_unsigned & (|(ld_raw & (ld_mask ^ (ld_mask >> 1))));
        ld_data = ld_sign ? (ld_raw | ~ld_mask) : (ld_raw & ld_mask);
    end

endmodule

// File: rtl/mips150_lsu.sv
// Handshaked MIPS150 load/store unit with misalignment/size checking.
// Optional watchdog on stalled memory transactions: define LSU_TIMEOUT_EN.
module mips150_lsu
    import mips150_lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W/8-1:0]  mem_be,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ADDR_W-1:0]    err_addr
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e          state_q, state_d;
    logic                store_q, store_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]          size_q, size_d, err_code_q, err_code_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, err_addr_q, err_addr_d;
    logic [4:0]          rd_q, rd_d;
    logic [NB-1:0]       be_q, be_d, lane_be;
    logic [DATA_W-1:0]   wdata_q, wdata_d, wb_data_q, wb_data_d, lane_wdata, lane_ld;
    logic                size_illegal, misaligned, timeout_hit;

    mips150_lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .st_size     (req_size),
        .st_offset   (req_addr[OFF_W-1:0]),
        .st_wdata    (req_wdata),
        .st_be       (lane_be),
        .st_data     (lane_wdata),
        .ld_size     (size_q),
        .ld_offset   (addr_q[OFF_W-1:0]),
        .ld_unsigned (uns_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (lane_ld)
    );

    assign size_illegal = (req_size == SZ_DWORD) && (DATA_W < 64);
    assign misaligned   = is_misaligned(req_size, req_addr[2:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Any state change is an entry into REQ/WAIT (or a leave), so it clears the count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ST_REQ || state_q == ST_WAIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_data_d  = wb_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (size_illegal || misaligned) begin
                        err_d      = 1'b1;
                        err_code_d = size_illegal ? ERR_SIZE : ERR_MISALIGN;
                        err_addr_d = req_addr;
                    end else begin
                        store_d = req_store;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        addr_d  = req_addr;
                        rd_d    = req_rd;
                        be_d    = req_store ? lane_be : '0;
                        wdata_d = req_store ? lane_wdata : '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = store_q ? ST_IDLE : ST_WAIT;
                end else if (timeout_hit) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    err_addr_d = addr_q;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    wb_data_d = lane_ld;
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    err_addr_d = addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            store_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            rd_q       <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_be        = (state_q == ST_REQ) ? be_q : '0;
    assign mem_wdata     = wdata_q;
    assign wb_valid      = (state_q == ST_RESP);
    assign wb_rd         = rd_q;
    assign wb_data       = wb_data_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_addr      = err_addr_q;

endmodule

// File: doc/mips150_lsu.md
Name: mips150_lsu

Overview:
Parametrised load/store unit for the MIPS150 pipeline. It replaces the fixed single-cycle store-mask, store-data and load-mask logic with a handshaked, multi-cycle memory interface that supports wait-states. Byte lanes are big-endian, width is configurable, and misalignment is detected. It sits between the X stage (request side) and the DMEM/IO memory map (memory side), and drives write-back data to the M stage.

Parameters:
- DATA_W, 32: memory data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; used only under LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  X stage presents a load/store
- req_ready  out  1  LSU can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- req_rd  in  5  destination register for loads
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero)
- mem_be  out  DATA_W/8  byte write enables; all zero for loads
- mem_wdata  out  DATA_W  lane-positioned store data
- mem_rsp_valid  in  1  load data valid
- mem_rdata  in  DATA_W  load data
- wb_valid  out  1  one-cycle write-back pulse
- wb_rd  out  5  write-back register
- wb_data  out  DATA_W  extended load result
- busy  out  1  state != IDLE; pipeline stall
- err  out  1  one-cycle error pulse
- err_code  out  2  1 misaligned, 2 timeout, 3 illegal size
- err_addr  out  ADDR_W  offending address

Behaviour:
- Reset (asynchronous, any state): state=IDLE. req_ready=1. mem_req_valid, mem_be, wb_valid, err and busy are 0. All data/address outputs are 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, register the request and go to REQ.
  - REQ: mem_req_valid=1; mem outputs held stable until mem_req_ready. Store handshake goes to IDLE. Load handshake goes to WAIT.
  - WAIT: on mem_rsp_valid, register the formatted result and go to RESP.
  - RESP: wb_valid=1 for one cycle, then IDLE.
- Latency with zero wait-states: store accept at cycle 0, handshake at cycle 1. Load accept at cycle 0, wb_valid at cycle 3 (response arriving cycle 2).
- mem_rsp_valid outside WAIT is ignored. A handshake and response in the same cycle is not supported; the response must arrive at least one cycle later.
- Lane mapping (big-endian): offset 0 maps to the MSB lane. For DATA_W=32, byte offsets 0..3 give mem_be 1000, 0100, 0010, 0001. Halfwords give 1100 / 0011.
- Store data is replicated into the selected lane(s); unselected lanes are 0.
- Load: extract the lane, then sign-extend or zero-extend to DATA_W. Word loads on DATA_W=64 are extended per req_unsigned.
- Misalignment: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0.
  - Checked at accept. No memory request is issued; the FSM stays in IDLE.
  - Next cycle: err=1, err_code=1, err_addr=req_addr.
- req_size=3 with DATA_W=32 is handled the same way, with err_code=3.
- req_ready is 0 in every state except IDLE; requests offered while busy are not consumed.
- wb_valid and err are never asserted in the same cycle.

Optional Feature:
- LSU_TIMEOUT_EN defined: a counter clears on entry to REQ or WAIT and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, pulse err with err_code=2 and err_addr = request address, no wb_valid.
  - A late mem_rsp_valid is then ignored.
- Undefined: no counter; the FSM waits indefinitely. err_code=2 is never produced.

Decomposition:
- Package mips150_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - err codes ERR_MISALIGN/ERR_TIMEOUT/ERR_SIZE;
  - the FSM state enum.
- Sub-module mips150_lsu_lane: purely combinational lane formatter.
  - Store side: be and wdata from size/offset.
  - Load side: extract and extend from size/offset/unsigned.
  - Instantiated once; the FSM stays in the top.

Test Plan:
- SB, addr=0x00000001, wdata=0x000000AB, mem_req_ready=1 → mem_be=4'b0100, mem_wdata=0x00AB0000, mem_addr=0x00000000; req_ready back to 1 on cycle 2.
- LB, addr=0x3, rdata=0x123456F0 → wb_data=0xFFFFFFF0, wb_rd echoed, wb_valid at cycle 3. Same access as LBU → 0x000000F0.
- LH, addr=0x2, rdata=0x1234ABCD → wb_data=0xFFFFABCD. LHU → 0x0000ABCD. LW, addr=0x4 → 0x1234ABCD.
- LW, addr=0x6 → no mem_req_valid; err=1, err_code=1, err_addr=0x6 next cycle; wb_valid stays 0.
- mem_req_ready low for 3 cycles, then rst pulsed mid-WAIT → mem outputs stable while stalled; reset forces IDLE, req_ready=1, busy=0 immediately (asynchronous).
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response → err_code=2 at the 16th WAIT-cycle; later mem_rsp_valid produces no wb_valid.
